// File: rtl/operand_issue_stage_pkg.sv
// Shared pipeline definitions: datapath width, register index width and the
// ID/EX bundle that the EX and MEM stages also carry.
package operand_issue_stage_pkg;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [REG_W-1:0] rd;
    logic             wb_en;
    logic             is_load;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
  } id_ex_t;

  typedef enum logic {ST_IDLE, ST_LOAD_WAIT} stall_state_t;

  // A producer supplies a source only if it really writes a non-zero rd that the consumer reads.
  function automatic logic src_match(input logic use_src, input logic [REG_W-1:0] rs,
                                     input logic valid, input logic wb_en,
                                     input logic [REG_W-1:0] rd);
    return use_src && valid && wb_en && (rd == rs) && (rs != REG_ZERO);
  endfunction
endpackage

// File: rtl/operand_issue_stage_if.sv
// Decode-side bundle: IF/ID instruction fields, register-file read port and stall back-pressure.
interface operand_issue_stage_if;
  import operand_issue_stage_pkg::*;
  logic             id_valid;
  logic [XLEN-1:0]  id_pc;
  logic [REG_W-1:0] id_rs1, id_rs2, id_rd;
  logic             id_use_rs1, id_use_rs2, id_wb_en, id_is_load;
  logic [REG_W-1:0] addr_rs1, addr_rs2;
  logic [XLEN-1:0]  data_rs1, data_rs2;
  logic             stall_id;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_wb_en, id_is_load, data_rs1, data_rs2,
    input  addr_rs1, addr_rs2, stall_id
  );
  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_wb_en, id_is_load, data_rs1, data_rs2,
    output addr_rs1, addr_rs2, stall_id
  );
endinterface

// File: rtl/operand_issue_stage_forward_select.sv
// Per-operand bypass mux: EX > MEM > WB > register file, x0 forced to zero.
module operand_issue_stage_forward_select
  import operand_issue_stage_pkg::*;
(
  input  logic             use_src,
  input  logic [REG_W-1:0] rs,
  input  logic [XLEN-1:0]  rf_data,
  input  logic             ex_valid,
  input  logic             ex_wb_en,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [XLEN-1:0]  ex_result,
  input  logic             mem_valid,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [XLEN-1:0]  mem_result,
  input  logic             wb_valid,
  input  logic             wb_en,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic [XLEN-1:0]  operand,
  output logic             load_hazard
);
  logic ex_hit, mem_hit, wb_hit;

  assign ex_hit      = src_match(use_src, rs, ex_valid, ex_wb_en, ex_rd);
  assign mem_hit     = src_match(use_src, rs, mem_valid, mem_wb_en, mem_rd);
  assign wb_hit      = src_match(use_src, rs, wb_valid, wb_en, wb_rd);
  assign load_hazard = ex_hit & ex_is_load;

  // A load in EX has no data yet; the resulting stall discards whatever is picked here.
  always_comb begin
    operand = rf_data;
    if (rs == REG_ZERO)            operand = '0;
    else if (ex_hit && !ex_is_load) operand = ex_result;
    else if (mem_hit)              operand = mem_result;
    else if (wb_hit)               operand = wb_data;
  end
endmodule

// File: rtl/operand_issue_stage.sv
// ID/EX boundary: operand bypassing, load-use stall, ID/EX register and event counters.
module operand_issue_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  operand_issue_stage_if.slave  id_bus,
  input  logic [XLEN-1:0]       ex_result,
  input  logic                  mem_valid,
  input  logic                  mem_wb_en,
  input  logic [4:0]            mem_rd,
  input  logic [XLEN-1:0]       mem_result,
  input  logic                  wb_valid,
  input  logic                  wb_en,
  input  logic [4:0]            wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic                  ex_wb_en,
  output logic                  ex_is_load,
  output logic [XLEN-1:0]       ex_pc,
  output logic [4:0]            ex_rd,
  output logic [XLEN-1:0]       ex_op1,
  output logic [XLEN-1:0]       ex_op2,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);
  import operand_issue_stage_pkg::id_ex_t;
  import operand_issue_stage_pkg::stall_state_t;
  import operand_issue_stage_pkg::ST_IDLE;
  import operand_issue_stage_pkg::ST_LOAD_WAIT;

  id_ex_t          ex_q;
  stall_state_t    state, state_nxt;
  logic [XLEN-1:0] op1, op2;
  logic            haz1, haz2, stall_id;

  assign id_bus.addr_rs1 = id_bus.id_rs1;
  assign id_bus.addr_rs2 = id_bus.id_rs2;

  operand_issue_stage_forward_select u_fwd1 (
    .use_src(id_bus.id_use_rs1), .rs(id_bus.id_rs1), .rf_data(id_bus.data_rs1),
    .ex_valid(ex_q.valid), .ex_wb_en(ex_q.wb_en), .ex_is_load(ex_q.is_load),
    .ex_rd(ex_q.rd), .ex_result(ex_result),
    .mem_valid(mem_valid), .mem_wb_en(mem_wb_en), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .operand(op1), .load_hazard(haz1)
  );

  operand_issue_stage_forward_select u_fwd2 (
    .use_src(id_bus.id_use_rs2), .rs(id_bus.id_rs2), .rf_data(id_bus.data_rs2),
    .ex_valid(ex_q.valid), .ex_wb_en(ex_q.wb_en), .ex_is_load(ex_q.is_load),
    .ex_rd(ex_q.rd), .ex_result(ex_result),
    .mem_valid(mem_valid), .mem_wb_en(mem_wb_en), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .operand(op2), .load_hazard(haz2)
  );

  // ex_q is cleared during reset, so no EX match and no stall can appear then.
  assign stall_id        = id_bus.id_valid & (haz1 | haz2) & ~flush;
  assign id_bus.stall_id = stall_id;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_q <= '0;
    end else if (flush || stall_id) begin
      ex_q.valid   <= 1'b0;
      ex_q.wb_en   <= 1'b0;
      ex_q.is_load <= 1'b0;
      ex_q.rd      <= '0;
    end else begin
      ex_q <= '{valid: id_bus.id_valid, pc: id_bus.id_pc, rd: id_bus.id_rd,
                wb_en: id_bus.id_wb_en, is_load: id_bus.id_is_load, op1: op1, op2: op2};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
      state       <= ST_IDLE;
    end else begin
      if (stall_id) stall_count <= stall_count + CNT_W'(1);
      if (flush)    flush_count <= flush_count + CNT_W'(1);
      state <= state_nxt;
    end
  end

  // The load has moved to MEM by the time we leave LOAD_WAIT, so one bubble always suffices.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (stall_id) state_nxt = ST_LOAD_WAIT;
      ST_LOAD_WAIT: state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always @(posedge clock)
    if (reset && state == ST_LOAD_WAIT) assert (!stall_id);

  assign ex_valid   = ex_q.valid;
  assign ex_wb_en   = ex_q.wb_en;
  assign ex_is_load = ex_q.is_load;
  assign ex_pc      = ex_q.pc;
  assign ex_rd      = ex_q.rd;
  assign ex_op1     = ex_q.op1;
  assign ex_op2     = ex_q.op2;
endmodule

// File: tb/tb_operand_issue_stage.sv
// Directed bench for operand_issue_stage: bypass paths, load-use stall, flush, x0, reset.
module tb_operand_issue_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ex_result, mem_result, wb_data;
  logic        mem_valid, mem_wb_en, wb_valid, wb_en, flush;
  logic [4:0]  mem_rd, wb_rd;
  logic        ex_valid, ex_wb_en, ex_is_load;
  logic [31:0] ex_pc, ex_op1, ex_op2;
  logic [4:0]  ex_rd;
  logic [31:0] stall_count, flush_count;
  int          errors = 0;
  int          checks = 0;

  operand_issue_stage_if bus ();

  operand_issue_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .id_bus(bus.slave),
    .ex_result(ex_result), .mem_valid(mem_valid), .mem_wb_en(mem_wb_en),
    .mem_rd(mem_rd), .mem_result(mem_result), .wb_valid(wb_valid), .wb_en(wb_en),
    .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .ex_valid(ex_valid), .ex_wb_en(ex_wb_en), .ex_is_load(ex_is_load),
    .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.id_valid = 0; bus.id_pc = '0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
    bus.id_use_rs1 = 0; bus.id_use_rs2 = 0; bus.id_wb_en = 0; bus.id_is_load = 0;
    bus.data_rs1 = '0; bus.data_rs2 = '0;
    ex_result = '0; mem_valid = 0; mem_wb_en = 0; mem_rd = '0; mem_result = '0;
    wb_valid = 0; wb_en = 0; wb_rd = '0; wb_data = '0; flush = 0;
  endtask

  task automatic instr(input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld);
    bus.id_valid = 1; bus.id_pc = pc; bus.id_rs1 = rs1; bus.id_use_rs1 = u1;
    bus.id_rs2 = rs2; bus.id_use_rs2 = u2; bus.id_rd = rd; bus.id_wb_en = we;
    bus.id_is_load = ld;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    #12;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_op1", ex_op1, 0);
    check("rst_stall_count", stall_count, 0);
    check("rst_flush_count", flush_count, 0);
    check("rst_stall_id", bus.stall_id, 0);
    reset = 1;

    // producer x5 enters EX
    instr(32'h100, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0);
    tick();
    check("prod_ex_valid", ex_valid, 1);
    check("prod_ex_rd", ex_rd, 5);
    check("prod_ex_pc", ex_pc, 32'h100);

    // consumer of x5: EX bypass, x2 from register file
    instr(32'h104, 5'd5, 1, 5'd2, 1, 5'd8, 1, 0);
    bus.data_rs1 = 32'h999; bus.data_rs2 = 32'h22; ex_result = 32'h10;
    #1 check("alu_dep_no_stall", bus.stall_id, 0);
    check("addr_rs1_copy", bus.addr_rs1, 5);
    tick();
    check("ex_bypass_op1", ex_op1, 32'h10);
    check("rf_op2", ex_op2, 32'h22);

    // lw x6 enters EX
    instr(32'h108, 5'd0, 0, 5'd0, 0, 5'd6, 1, 1);
    ex_result = 32'h0;
    tick();
    check("load_in_ex", ex_is_load, 1);

    // add x7 = x6 + x1 -> one bubble
    instr(32'h10c, 5'd6, 1, 5'd1, 1, 5'd7, 1, 0);
    bus.data_rs1 = 32'h0; bus.data_rs2 = 32'h11; ex_result = 32'hBAD;
    #1 check("load_use_stall", bus.stall_id, 1);
    tick();
    check("bubble_ex_valid", ex_valid, 0);
    check("bubble_ex_wb_en", ex_wb_en, 0);
    check("stall_count_1", stall_count, 1);

    // load now in MEM, same ID instruction retried
    mem_valid = 1; mem_wb_en = 1; mem_rd = 5'd6; mem_result = 32'h4000;
    #1 check("no_second_stall", bus.stall_id, 0);
    tick();
    check("mem_bypass_valid", ex_valid, 1);
    check("mem_bypass_op1", ex_op1, 32'h4000);
    check("mem_bypass_op2", ex_op2, 32'h11);
    check("mem_bypass_rd", ex_rd, 7);
    check("stall_count_hold", stall_count, 1);

    // WB-cycle bypass of x9; rs1 = x0 reads zero despite stale regfile value
    idle_inputs();
    instr(32'h110, 5'd0, 1, 5'd9, 1, 5'd0, 1, 0);
    bus.data_rs1 = 32'h77; bus.data_rs2 = 32'h0;
    wb_valid = 1; wb_en = 1; wb_rd = 5'd9; wb_data = 32'hDEADBEEF;
    tick();
    check("wb_bypass_op2", ex_op2, 32'hDEADBEEF);
    check("x0_op1_rf", ex_op1, 0);

    // producer with rd = x0 is now in EX; consumer of x0 still reads 0
    idle_inputs();
    instr(32'h114, 5'd0, 1, 5'd0, 0, 5'd3, 1, 0);
    bus.data_rs1 = 32'h55; ex_result = 32'h55;
    mem_valid = 1; mem_wb_en = 1; mem_rd = 5'd0; mem_result = 32'h55;
    tick();
    check("x0_producer_op1", ex_op1, 0);

    // x3 written by EX, MEM and WB at once -> EX wins
    idle_inputs();
    instr(32'h118, 5'd3, 1, 5'd3, 1, 5'd10, 0, 0);
    bus.data_rs1 = 32'h99; bus.data_rs2 = 32'h99; ex_result = 32'h1;
    mem_valid = 1; mem_wb_en = 1; mem_rd = 5'd3; mem_result = 32'h2;
    wb_valid = 1; wb_en = 1; wb_rd = 5'd3; wb_data = 32'h3;
    tick();
    check("prio_ex_op1", ex_op1, 1);
    check("prio_ex_op2", ex_op2, 1);

    // MEM beats WB; unused rs2 takes the register file
    ex_result = 32'h0;
    instr(32'h11c, 5'd3, 1, 5'd3, 0, 5'd0, 0, 0);
    tick();
    check("prio_mem_op1", ex_op1, 2);
    check("unused_rs2_rf", ex_op2, 32'h99);

    // flush during a load-use hazard
    idle_inputs();
    instr(32'h120, 5'd0, 0, 5'd0, 0, 5'd12, 1, 1);
    tick();
    instr(32'h124, 5'd12, 1, 5'd0, 0, 5'd13, 1, 0);
    flush = 1;
    #1 check("flush_beats_stall", bus.stall_id, 0);
    tick();
    flush = 0;
    check("flush_ex_valid", ex_valid, 0);
    check("flush_ex_wb_en", ex_wb_en, 0);
    check("flush_count_1", flush_count, 1);
    check("flush_stall_count", stall_count, 1);

    // reset in the middle of a stall, between edges
    instr(32'h128, 5'd0, 0, 5'd0, 0, 5'd13, 1, 1);
    tick();
    instr(32'h12c, 5'd0, 0, 5'd13, 1, 5'd14, 1, 0);
    #1 check("pre_reset_stall", bus.stall_id, 1);
    #1 reset = 0;
    #1;
    check("midrst_stall_id", bus.stall_id, 0);
    check("midrst_ex_is_load", ex_is_load, 0);
    check("midrst_ex_pc", ex_pc, 0);
    check("midrst_ex_rd", ex_rd, 0);
    check("midrst_stall_count", stall_count, 0);
    check("midrst_flush_count", flush_count, 0);
    #1 reset = 1;
    idle_inputs();
    instr(32'h200, 5'd4, 1, 5'd0, 0, 5'd5, 1, 0);
    bus.data_rs1 = 32'h44;
    tick();
    check("post_rst_valid", ex_valid, 1);
    check("post_rst_op1", ex_op1, 32'h44);
    check("post_rst_pc", ex_pc, 32'h200);
    check("post_rst_stall_count", stall_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/operand_issue_stage.md
# operand_issue_stage

Decode-to-execute boundary stage that sits directly downstream of the register file. It drives the register-file read addresses and captures the returned operands. It resolves RAW hazards by bypassing from EX, MEM and WB, and detects load-use hazards and stalls for them. It registers the resolved operands and control into the ID/EX pipeline register, inserting bubbles on stall or flush, and keeps stall and flush event counters.

## Interface
Parameters:
- XLEN, 32, datapath width
- CNT_W, 32, width of event counters

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  IF/ID holds a valid instruction
- id_pc  in  XLEN  PC of ID instruction
- id_rs1, id_rs2, id_rd  in  5 each  register addresses
- id_use_rs1, id_use_rs2  in  1 each  instruction actually reads rs1/rs2
- id_wb_en  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- addr_rs1, addr_rs2  out  5 each  to register file; combinational copies of id_rs1/id_rs2
- data_rs1, data_rs2  in  XLEN each  register-file read data, combinational
- ex_result  in  XLEN  ALU result of the instruction currently in EX
- mem_valid, mem_wb_en  in  1 each  MEM-stage producer info
- mem_rd  in  5  MEM-stage destination register
- mem_result  in  XLEN  MEM-stage writeback value, including load data
- wb_valid, wb_en  in  1 each  WB-stage producer info; same write as register file write_enable
- wb_rd  in  5  WB-stage destination register
- wb_data  in  XLEN  WB-stage value
- flush  in  1  branch/jump redirect from EX; kill ID and the instruction entering EX
- stall_id  out  1  hold PC and IF/ID this cycle
- ex_valid, ex_wb_en, ex_is_load  out  1 each  ID/EX register
- ex_pc  out  XLEN  ID/EX register
- ex_rd  out  5  ID/EX register
- ex_op1, ex_op2  out  XLEN  resolved operands
- stall_count, flush_count  out  CNT_W  event counters

## Operation
- Match condition for source s (rs1/rs2) against a producer: id_use_s, producer valid, producer wb_en, producer rd == id_s, id_s != 0.
- Operand selection priority, per operand:
  1. EX: match against the ID/EX register, with ex_is_load = 0 -> ex_result.
  2. MEM: match -> mem_result.
  3. WB: match -> wb_data. The register file commits only at the clock edge, so its read data is stale in the WB cycle.
  4. Otherwise -> data_rs*.
- id_s == 0 always selects 0, regardless of producers.
- Load-use hazard: id_valid, and an EX match where ex_is_load = 1.
- stall_id = hazard & ~flush.
- Register update, per edge, in priority order:
  - flush -> ex_valid <= 0, and all control outputs <= 0.
  - else stall_id -> bubble. ex_valid, ex_wb_en and ex_is_load <= 0; ex_rd <= 0.
  - else -> capture id_* and the resolved operands. ex_valid <= id_valid.
- Bubbles and invalid entries never act as forwarding sources: all control fields are cleared in them.
- stall_count increments on each cycle where stall_id = 1; flush_count increments on each flush cycle.
- Both counters wrap modulo 2^CNT_W.
- Stall state machine, two states:
  - IDLE -> LOAD_WAIT on stall_id.
  - LOAD_WAIT -> IDLE unconditionally, because the load has advanced to MEM and is bypassed from there.
  - A second back-to-back stall is impossible by construction. Assert this in simulation.

## Timing
- ID/EX outputs are valid one cycle after capture. Operand resolution is zero-latency combinational within the ID cycle.
- A load-use hazard costs exactly 1 bubble cycle.
- Simultaneous flush and stall: flush wins; stall_id = 0.
- Simultaneous matches from EX, MEM and WB: youngest (EX) wins.
- Reset asserted, asynchronously and at any time, forces:
  - ex_valid, ex_wb_en, ex_is_load = 0
  - ex_pc, ex_rd, ex_op1, ex_op2 = 0
  - both counters = 0
  - state = IDLE
- stall_id reads 0 during reset. A stall in progress is discarded.
- After reset release, the first capture occurs on the first rising edge.

## Structure
- Shared pipeline package: XLEN, the register-index width (5), the zero-register constant, and the ID/EX bundle typedef (valid, pc, rd, wb_en, is_load, op1, op2). EX and MEM stages reuse this typedef.
- One natural sub-module, forward_select. It is instantiated per operand and is purely combinational: priority mux plus match logic.
- The hazard FSM, counters and ID/EX register stay in the top module.

## Test plan
- Back-to-back ALU dependency: producer x5 = 0x10 in EX, consumer reads x5 -> ex_op1 = 0x10 next cycle, no stall.
- Load-use: lw x6 in EX, add x7 = x6 + x1 in ID -> stall_id = 1 for 1 cycle, one bubble (ex_valid = 0). Then ex_op1 = the load data via the MEM bypass; stall_count = 1.
- WB-cycle bypass: WB writes x9 = 0xDEAD_BEEF while the regfile still returns 0 -> ex_op2 = 0xDEADBEEF.
- x0 and priority:
  - Producer rd = 0 with value 0x55 -> operand reads 0.
  - EX, MEM and WB all writing x3 (values 1, 2, 3) -> operand = 1.
- Flush during load-use stall -> stall_id = 0, ex_valid = 0 next cycle, flush_count = 1, stall_count unchanged.
- Reset asserted mid-stall, between edges -> all outputs are 0 immediately; after release, normal capture resumes with the counters at 0.
